// File: rtl/mem_multi_bank_masked_clear.sv
// Banked simple-dual-port memory with a masked, parallel bank clear and 0/1/2-cycle read latency.
// Optional feature macro: MEM_MULTI_BANK_MASKED_CLEAR_FWD_EN (same-cycle write-to-read forwarding).
//
// state       | meaning
// ST_IDLE     | no clear running; host has full read/write access to every bank
// ST_CLEARING | banks in r_active_mask get DEFAULT_VALUE written at r_clr_addr every cycle
module mem_multi_bank_masked_clear #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    DEPTH         = 16,
  parameter int                    NUM_BANKS     = 4,
  parameter int                    OUTPUT_DELAY  = 1,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter int                    BANK_WIDTH    = $clog2(NUM_BANKS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_req,
  input  logic [NUM_BANKS-1:0]     clear_mask,
  output logic                     busy,
  output logic                     clear_done_pulse,
  input  logic                     wea,
  input  logic [BANK_WIDTH-1:0]    banka,
  input  logic [$clog2(DEPTH)-1:0] addra,
  input  logic [DATA_WIDTH-1:0]    dia,
  input  logic                     reb,
  input  logic [BANK_WIDTH-1:0]    bankb,
  input  logic [$clog2(DEPTH)-1:0] addrb,
  output logic [DATA_WIDTH-1:0]    dob
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [BANK_WIDTH:0]   LP_NB    = (BANK_WIDTH+1)'(NUM_BANKS);
  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [NUM_BANKS-1:0]    r_active_mask, w_mask_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_addr, w_addr_nxt;
  logic                    r_done, w_done_nxt;
  logic                    w_busy;

  logic [DATA_WIDTH-1:0]   r_mem [NUM_BANKS][DEPTH];

  logic                    w_wa_ok, w_ra_ok, w_host_we, w_shadow;
  logic [DATA_WIDTH-1:0]   w_rd_arr, w_rd_val;

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_active_mask <= '0;
      r_clr_addr    <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_active_mask <= w_mask_nxt;
      r_clr_addr    <= w_addr_nxt;
      r_done        <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_active_mask;
    w_addr_nxt  = r_clr_addr;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (clear_req) begin
          if (|clear_mask) begin
            w_state_nxt = ST_CLEARING;
            w_mask_nxt  = clear_mask;
            w_addr_nxt  = '0;
          end else begin
            // Empty mask: nothing to clear, but the requester still gets its completion pulse.
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_CLEARING: begin
        if (r_clr_addr == LP_LAST) begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
          w_addr_nxt  = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_addr_nxt  = r_clr_addr + ADDR_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_mask_nxt  = '0;
        w_addr_nxt  = '0;
      end
    endcase
  end

  assign w_busy           = (r_state == ST_CLEARING);
  assign busy             = w_busy;
  assign clear_done_pulse = r_done;

  // ---------------- array write port ----------------
  assign w_wa_ok   = ({1'b0, banka} < LP_NB) && ({1'b0, addra} < LP_DEPTH);
  assign w_host_we = wea && w_wa_ok && !(w_busy && r_active_mask[banka]);

  // Host writes never target a bank under clear, so each bank sees at most one writer per cycle.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_busy && r_active_mask[b]) begin
        r_mem[b][r_clr_addr] <= DEFAULT_VALUE;
      end else if (w_host_we && (banka == BANK_WIDTH'(b))) begin
        r_mem[b][addra] <= dia;
      end
    end
  end

  // ---------------- array read port ----------------
  assign w_ra_ok  = ({1'b0, bankb} < LP_NB) && ({1'b0, addrb} < LP_DEPTH);
  assign w_rd_arr = w_ra_ok ? r_mem[bankb][addrb] : DEFAULT_VALUE;
  assign w_shadow = w_busy && w_ra_ok && r_active_mask[bankb];

`ifdef MEM_MULTI_BANK_MASKED_CLEAR_FWD_EN
  logic w_fwd;
  assign w_fwd    = w_host_we && (banka == bankb) && (addra == addrb);
  assign w_rd_val = w_shadow ? DEFAULT_VALUE : (w_fwd ? dia : w_rd_arr);
`else
  assign w_rd_val = w_shadow ? DEFAULT_VALUE : w_rd_arr;
`endif

  // Shadow/forward are resolved at issue time, so the pipeline carries the final word and later
  // mask changes cannot alter a read already in flight.
  generate
    if (OUTPUT_DELAY == 0) begin : g_lat0
      assign dob = w_rd_val;
    end else if (OUTPUT_DELAY == 1) begin : g_lat1
      logic [DATA_WIDTH-1:0] r_dob;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_dob <= DEFAULT_VALUE;
        end else if (reb) begin
          r_dob <= w_rd_val;
        end
      end
      assign dob = r_dob;
    end else begin : g_lat2
      logic [DATA_WIDTH-1:0] r_rd1;
      logic                  r_rd1_vld;
      logic [DATA_WIDTH-1:0] r_dob;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rd1     <= DEFAULT_VALUE;
          r_rd1_vld <= 1'b0;
          r_dob     <= DEFAULT_VALUE;
        end else begin
          r_rd1_vld <= reb;
          if (reb) begin
            r_rd1 <= w_rd_val;
          end
          if (r_rd1_vld) begin
            r_dob <= r_rd1;
          end
        end
      end
      assign dob = r_dob;
    end
  endgenerate

endmodule

// File: tb/tb_mem_multi_bank_masked_clear.sv
// Directed self-checking bench for mem_multi_bank_masked_clear, three instances at read latency 0/1/2
// sharing one stimulus stream; collision expectation follows MEM_MULTI_BANK_MASKED_CLEAR_FWD_EN.
module tb_mem_multi_bank_masked_clear;

`ifdef MEM_MULTI_BANK_MASKED_CLEAR_FWD_EN
  localparam logic [7:0] EXP_COLL = 8'h3C;
`else
  localparam logic [7:0] EXP_COLL = 8'h11;
`endif

  logic       clk;
  logic       reset_n;
  logic       clear_req;
  logic [3:0] clear_mask;
  logic       wea;
  logic [1:0] banka;
  logic [3:0] addra;
  logic [7:0] dia;
  logic       reb;
  logic [1:0] bankb;
  logic [3:0] addrb;
  logic       busy1, done1, busy0, done0, busy2, done2;
  logic [7:0] dob1, dob0, dob2;

  int n_checks = 0;
  int n_fail   = 0;

  mem_multi_bank_masked_clear #(.DATA_WIDTH(8), .DEPTH(16), .NUM_BANKS(4), .OUTPUT_DELAY(1),
                                .DEFAULT_VALUE(8'h00)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_mask(clear_mask),
    .busy(busy1), .clear_done_pulse(done1), .wea(wea), .banka(banka), .addra(addra), .dia(dia),
    .reb(reb), .bankb(bankb), .addrb(addrb), .dob(dob1));

  mem_multi_bank_masked_clear #(.DATA_WIDTH(8), .DEPTH(16), .NUM_BANKS(4), .OUTPUT_DELAY(0),
                                .DEFAULT_VALUE(8'h00)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_mask(clear_mask),
    .busy(busy0), .clear_done_pulse(done0), .wea(wea), .banka(banka), .addra(addra), .dia(dia),
    .reb(reb), .bankb(bankb), .addrb(addrb), .dob(dob0));

  mem_multi_bank_masked_clear #(.DATA_WIDTH(8), .DEPTH(16), .NUM_BANKS(4), .OUTPUT_DELAY(2),
                                .DEFAULT_VALUE(8'h00)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_mask(clear_mask),
    .busy(busy2), .clear_done_pulse(done2), .wea(wea), .banka(banka), .addra(addra), .dia(dia),
    .reb(reb), .bankb(bankb), .addrb(addrb), .dob(dob2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: called right after a falling edge, return right after the next one.
  task automatic do_write(input logic [1:0] b, input logic [3:0] a, input logic [7:0] d);
    banka = b; addra = a; dia = d; wea = 1'b1;
    @(negedge clk);
    wea = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] b, input logic [3:0] a, output logic [7:0] d);
    bankb = b; addrb = a; reb = 1'b1;
    @(negedge clk);
    reb = 1'b0;
    d = dob1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clear_req = 1'b0; clear_mask = 4'h0; wea = 1'b0; reb = 1'b0;
    banka = 2'd0; addra = 4'd0; dia = 8'h00; bankb = 2'd0; addrb = 4'd0;
    @(negedge clk);
    n_checks++; if (busy1 !== 1'b0 || busy0 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b/%b/%b expected 0", busy1, busy0, busy2); end
    n_checks++; if (done1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", done1); end
    n_checks++; if (dob1 !== 8'h00) begin
      n_fail++; $display("FAIL reset_dob1: got %h expected 00", dob1); end
    n_checks++; if (dob2 !== 8'h00) begin
      n_fail++; $display("FAIL reset_dob2: got %h expected 00", dob2); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    logic [7:0] exp;
    for (int b = 0; b < 4; b++) do_write(2'(b), 4'd5, 8'hA0 + 8'(b));
    // Back-to-back reads of addr 5 in banks 0..3, then idle cycles to confirm dob holds.
    for (int c = 0; c <= 6; c++) begin
      if (c >= 1) begin
        exp = 8'hA0 + 8'((c - 1 > 3) ? 3 : c - 1);
        n_checks++; if (dob1 !== exp) begin
          n_fail++; $display("FAIL rd_lat1 c=%0d: got %h expected %h", c, dob1, exp); end
      end
      if (c >= 2) begin
        exp = 8'hA0 + 8'((c - 2 > 3) ? 3 : c - 2);
        n_checks++; if (dob2 !== exp) begin
          n_fail++; $display("FAIL rd_lat2 c=%0d: got %h expected %h", c, dob2, exp); end
      end
      if (c <= 3) begin
        reb = 1'b1; bankb = 2'(c); addrb = 4'd5;
        #1;
        exp = 8'hA0 + 8'(c);
        n_checks++; if (dob0 !== exp) begin
          n_fail++; $display("FAIL rd_lat0 c=%0d: got %h expected %h", c, dob0, exp); end
      end else begin
        reb = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_masked_clear;
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [7:0] d;
    logic [7:0] exp5 [4];
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    exp5[0] = 8'h00; exp5[1] = 8'hA1; exp5[2] = 8'h00; exp5[3] = 8'hA3;
    clear_req = 1'b1; clear_mask = 4'b0101;
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      if (busy1) busy_cnt++;
      if (done1) begin done_cnt++; done_at = c; end
      if (c == 5) begin
        n_checks++; if (dob1 !== 8'h00) begin
          n_fail++; $display("FAIL shadow_b0a5: got %h expected 00", dob1); end
      end
      if (c == 13) begin
        n_checks++; if (dob1 !== 8'hA3) begin
          n_fail++; $display("FAIL unshadowed_b3a5: got %h expected a3", dob1); end
      end
      wea = 1'b0; reb = 1'b0; clear_req = 1'b0;
      case (c)
        4:  begin reb = 1'b1; bankb = 2'd0; addrb = 4'd5; end
        8:  begin clear_req = 1'b1; clear_mask = 4'b1111; end
        10: begin wea = 1'b1; banka = 2'd2; addra = 4'd3; dia = 8'h77; end
        11: begin wea = 1'b1; banka = 2'd1; addra = 4'd3; dia = 8'h55; end
        12: begin reb = 1'b1; bankb = 2'd3; addrb = 4'd5; end
        default: ;
      endcase
      @(negedge clk);
    end
    wea = 1'b0; reb = 1'b0; clear_req = 1'b0;
    n_checks++; if (busy_cnt !== 16) begin
      n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 16", busy_cnt); end
    n_checks++; if (done_cnt !== 1 || done_at !== 17) begin
      n_fail++; $display("FAIL clear_done_pulse: got count %0d at %0d expected 1 at 17", done_cnt, done_at); end
    for (int b = 0; b < 4; b++) begin
      do_read(2'(b), 4'd5, d);
      n_checks++; if (d !== exp5[b]) begin
        n_fail++; $display("FAIL post_clear_b%0da5: got %h expected %h", b, d, exp5[b]); end
    end
    do_read(2'd2, 4'd3, d);
    n_checks++; if (d !== 8'h00) begin
      n_fail++; $display("FAIL dropped_write_b2a3: got %h expected 00", d); end
    do_read(2'd1, 4'd3, d);
    n_checks++; if (d !== 8'h55) begin
      n_fail++; $display("FAIL kept_write_b1a3: got %h expected 55", d); end
    do_read(2'd0, 4'd15, d);
    n_checks++; if (d !== 8'h00) begin
      n_fail++; $display("FAIL cleared_b0a15: got %h expected 00", d); end
  endtask

  task automatic test_reset_mid_clear;
    int done_cnt;
    logic [7:0] d;
    logic [7:0] exp;
    done_cnt = 0;
    for (int a = 0; a < 16; a++) do_write(2'd0, 4'(a), 8'h10 + 8'(a));
    clear_req = 1'b1; clear_mask = 4'b0001;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy: got %b expected 0", busy1); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done1) done_cnt++;
      @(negedge clk);
    end
    n_checks++; if (done_cnt !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt); end
    for (int a = 0; a < 16; a++) begin
      if (a != 7) begin
        do_read(2'd0, 4'(a), d);
        exp = (a <= 6) ? 8'h00 : 8'h10 + 8'(a);
        n_checks++; if (d !== exp) begin
          n_fail++; $display("FAIL partial_clear_a%0d: got %h expected %h", a, d, exp); end
      end
    end
  endtask

  task automatic test_zero_mask;
    clear_req = 1'b1; clear_mask = 4'b0000;
    @(negedge clk);
    clear_req = 1'b0;
    n_checks++; if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL zero_mask_busy: got %b expected 0", busy1); end
    n_checks++; if (done1 !== 1'b1 || done0 !== 1'b1 || done2 !== 1'b1) begin
      n_fail++; $display("FAIL zero_mask_done: got %b/%b/%b expected 1", done1, done0, done2); end
    @(negedge clk);
    n_checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL zero_mask_after: got done %b busy %b expected 0 0", done1, busy1); end
  endtask

  task automatic test_collision;
    logic [7:0] d;
    do_write(2'd3, 4'd9, 8'h11);
    wea = 1'b1; banka = 2'd3; addra = 4'd9; dia = 8'h3C;
    reb = 1'b1; bankb = 2'd3; addrb = 4'd9;
    #1;
    n_checks++; if (dob0 !== EXP_COLL) begin
      n_fail++; $display("FAIL coll_lat0: got %h expected %h", dob0, EXP_COLL); end
    @(negedge clk);
    wea = 1'b0; reb = 1'b0;
    n_checks++; if (dob1 !== EXP_COLL) begin
      n_fail++; $display("FAIL coll_lat1: got %h expected %h", dob1, EXP_COLL); end
    @(negedge clk);
    n_checks++; if (dob2 !== EXP_COLL) begin
      n_fail++; $display("FAIL coll_lat2: got %h expected %h", dob2, EXP_COLL); end
    do_read(2'd3, 4'd9, d);
    n_checks++; if (d !== 8'h3C) begin
      n_fail++; $display("FAIL coll_written: got %h expected 3c", d); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_masked_clear;
    test_zero_mask;
    test_collision;
    test_reset_mid_clear;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
